// File: rtl/oam_dma_if.sv
// CPU-side bus bundle seen by the sprite DMA engine: cpu requests in, muxed bus out.
// master = DMA engine side, slave = cpu core / bus fabric side.
interface oam_dma_if;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDataWr;
  logic        cpuWrEn;
  logic [7:0]  busDataRd;
  logic [15:0] busAddr;
  logic [7:0]  busDataWr;
  logic        busWrEn;
  logic        cpuHalt;
  logic        dmaActive;

  modport master (
    input  cpuAddr, cpuDataWr, cpuWrEn, busDataRd,
    output busAddr, busDataWr, busWrEn, cpuHalt, dmaActive
  );

  modport slave (
    output cpuAddr, cpuDataWr, cpuWrEn, busDataRd,
    input  busAddr, busDataWr, busWrEn, cpuHalt, dmaActive
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies one page into OAM.
// Optional macro OAM_DMA_ALIGN_EN adds a get/put alignment cycle after HALT.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic      cpuClk,
  input  logic      reset,
  oam_dma_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
`ifdef OAM_DMA_ALIGN_EN
    ALIGN,
`endif
    READ,
    WRITE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_latch;
  logic        r_cycleOdd;
  logic        r_cpuHalt;
  logic        r_dmaActive;

  logic [15:0] w_busAddr;
  logic [7:0]  w_busDataWr;
  logic        w_busWrEn;

  // cpuHalt/dmaActive are registered alongside the state so they never glitch.
  always_ff @(posedge cpuClk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_page      <= 8'h00;
      r_idx       <= 8'h00;
      r_latch     <= 8'h00;
      r_cycleOdd  <= 1'b0;
      r_cpuHalt   <= 1'b0;
      r_dmaActive <= 1'b0;
    end else begin
      r_cycleOdd <= ~r_cycleOdd;
      case (r_state)
        IDLE: begin
          if (bus.cpuWrEn && (bus.cpuAddr == DMA_REG_ADDR)) begin
            r_page      <= bus.cpuDataWr;
            r_idx       <= 8'h00;
            r_state     <= HALT;
            r_cpuHalt   <= 1'b1;
            r_dmaActive <= 1'b1;
          end
        end
        HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          r_state <= r_cycleOdd ? ALIGN : READ;
`else
          r_state <= READ;
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        ALIGN: r_state <= READ;
`endif
        READ: begin
          r_latch <= bus.busDataRd;
          r_state <= WRITE;
        end
        WRITE: begin
          if (r_idx == LAST_IDX) begin
            r_state     <= IDLE;
            r_cpuHalt   <= 1'b0;
            r_dmaActive <= 1'b0;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= READ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus ownership: cpu passes straight through unless the engine is reading or writing.
  always_comb begin
    w_busAddr   = bus.cpuAddr;
    w_busDataWr = bus.cpuDataWr;
    w_busWrEn   = bus.cpuWrEn;
    case (r_state)
      IDLE: ;
      READ: begin
        w_busAddr = {r_page, r_idx};
        w_busWrEn = 1'b0;
      end
      WRITE: begin
        w_busAddr   = OAM_DATA_ADDR;
        w_busDataWr = r_latch;
        w_busWrEn   = 1'b1;
      end
      default: w_busWrEn = 1'b0;
    endcase
  end

  assign bus.busAddr   = w_busAddr;
  assign bus.busDataWr = w_busDataWr;
  assign bus.busWrEn   = w_busWrEn;
  assign bus.cpuHalt   = r_cpuHalt;
  assign bus.dmaActive = r_dmaActive;

endmodule
